// File: rtl/fifo_arb_pkg.sv
// Shared encodings and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OPEN      = 1'b0,
    THROTTLED = 1'b1
  } thr_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_HIGH_MARK = 5;
  localparam int DEF_LOW_MARK  = 2;
  localparam int DEF_BURST_LEN = 2;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or after rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port, gated by a
// watermark hysteresis on the FIFO fill level.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int HIGH_MARK = DEF_HIGH_MARK,
  parameter int LOW_MARK  = DEF_LOW_MARK,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic [CNT_W-1:0]          fifo_words,
  input  logic                      fifo_full,
  output logic                      throttled
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int BC_W  = idx_width(BURST_LEN);
  localparam logic [CNT_W-1:0] HIGH_LVL  = CNT_W'(HIGH_MARK);
  localparam logic [CNT_W-1:0] LOW_LVL   = CNT_W'(LOW_MARK);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t          arb_state;
  thr_state_t          thr_state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    next_ptr;
  logic [BC_W-1:0]     burst_cnt;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                owner_req;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign throttled = (thr_state == THROTTLED);
  assign next_ptr  = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

  // Writes are suppressed during reset so a mid-burst reset never lands a word.
  always_comb begin
    owner_req = req[owner];
    wr_en     = rst_n && (arb_state == GRANT) && owner_req && !throttled && !fifo_full;
    ack       = grant & {NUM_REQ{wr_en}};
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) fifo_data = fifo_data | req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_state <= OPEN;
    end else begin
      case (thr_state)
        OPEN:      if (fifo_words >= HIGH_LVL) thr_state <= THROTTLED;
        THROTTLED: if (fifo_words <= LOW_LVL)  thr_state <= OPEN;
      endcase
    end
  end

  // fifo_full alone only stalls: grant is kept and the beat count frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arb_state <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (arb_state)
        IDLE: begin
          if (!throttled && pick_valid) begin
            grant     <= pick_onehot;
            owner     <= pick_idx;
            burst_cnt <= '0;
            arb_state <= GRANT;
          end
        end
        GRANT: begin
          if ((wr_en && burst_cnt == LAST_BEAT) || !owner_req || throttled) begin
            grant     <= '0;
            rr_ptr    <= next_ptr;
            arb_state <= IDLE;
          end else if (wr_en) begin
            burst_cnt <= burst_cnt + BC_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario tests plus a randomized run, all checked against a cycle model
// of the arbitration rules kept in the bench.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int HIGH  = 5;
  localparam int LOW   = 2;
  localparam int BURST = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic [N-1:0]  grant;
  logic          wr_en;
  logic [DW-1:0] fifo_data;
  logic [3:0]    fifo_words;
  logic          fifo_full;
  logic          throttled;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner is -1 when nobody holds the port.
  int   m_owner, m_ptr, m_cnt;
  bit   m_thr;
  logic [N-1:0]  e_grant, e_ack;
  logic          e_wr, e_thr;
  logic [DW-1:0] e_data;

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .wr_en     (wr_en),
    .fifo_data (fifo_data),
    .fifo_words(fifo_words),
    .fifo_full (fifo_full),
    .throttled (throttled)
  );

  always #5 clk = ~clk;

  function automatic string obs_str();
    return $sformatf("grant=%b ack=%b wr_en=%b data=%h thr=%b", grant, ack, wr_en, fifo_data, throttled);
  endfunction

  function automatic string exp_str();
    return $sformatf("grant=%b ack=%b wr_en=%b data=%h thr=%b", e_grant, e_ack, e_wr, e_data, e_thr);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_thr   = 1'b0;
  endtask

  function automatic bit model_write();
    if (!rst_n || m_owner < 0) return 1'b0;
    return req[m_owner] && !m_thr && !fifo_full;
  endfunction

  task automatic sample();
    @(negedge clk);
    e_wr    = model_write();
    e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_ack   = e_wr ? e_grant : '0;
    e_data  = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
    e_thr   = m_thr;
  endtask

  task automatic advance();
    bit wr;
    wr = model_write();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_owner < 0) begin
        if (!m_thr) begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_owner < 0 && req[i]) begin
              m_owner = i;
              m_cnt   = 0;
            end
          end
        end
      end else begin
        if (wr) m_cnt++;
        if ((wr && m_cnt == BURST) || !req[m_owner] || m_thr) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
      m_thr = m_thr ? (int'(fifo_words) > LOW) : (int'(fifo_words) >= HIGH);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; fifo_full = 1'b0; fifo_words = '0;
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0; req = 4'b1111; fifo_words = '0; fifo_full = 1'b0;
    req_data = 32'hD4C3_B2A1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      sample();
      vectors++;
      if ({wr_en, grant, ack} !== 9'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold%0d: got %s, want wr_en/grant/ack all 0", c, obs_str());
      end
      advance();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL reset_model%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      if (c == 1) begin
        vectors++;
        if (grant !== 4'b0001) begin
          miscompares++;
          $display("[TB] FAIL reset_first_grant: got grant=%b, want 0001", grant);
        end
      end
      advance();
    end
  endtask

  task automatic test_single_requester();
    int writes;
    writes = 0;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL single_c%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      if (wr_en === 1'b1) begin
        writes++;
        vectors++;
        if (fifo_data !== 8'hA1) begin
          miscompares++;
          $display("[TB] FAIL single_data_c%0d: got %h, want a1", c, fifo_data);
        end
      end
      advance();
    end
    vectors++;
    if (writes != 6) begin
      miscompares++;
      $display("[TB] FAIL single_write_count: got %0d, want 6", writes);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int want[8] = '{0, 0, 1, 1, 3, 3, 0, 0};
    do_reset();
    req = 4'b1011;
    for (int c = 1; c <= 12; c++) begin
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL rr_c%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      if (wr_en === 1'b1) begin
        for (int i = 0; i < N; i++) if (ack[i]) order.push_back(i);
      end
      advance();
    end
    vectors++;
    if (order.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL rr_write_count: got %0d, want 8", order.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (order[k] != want[k]) begin
          miscompares++;
          $display("[TB] FAIL rr_order%0d: got owner %0d, want %0d", k, order[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_throttle();
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 10; c++) begin
      fifo_words = (c < 2) ? 4'd0 : (c < 5) ? 4'd5 : (c < 8) ? 4'd3 : 4'd2;
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL thr_c%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      if (c == 3 || c == 7) begin
        vectors++;
        if ({throttled, wr_en} !== 2'b10) begin
          miscompares++;
          $display("[TB] FAIL thr_closed_c%0d: got thr=%b wr_en=%b, want thr=1 wr_en=0", c, throttled, wr_en);
        end
      end
      if (c == 4 || c == 9) begin
        vectors++;
        if (grant !== 4'b0000 || throttled !== (c == 4)) begin
          miscompares++;
          $display("[TB] FAIL thr_idle_c%0d: got grant=%b thr=%b, want grant=0000 thr=%b", c, grant, throttled, c == 4);
        end
      end
      if (c == 10) begin
        vectors++;
        if (grant !== 4'b0010) begin
          miscompares++;
          $display("[TB] FAIL thr_reopen_grant: got %b, want 0010", grant);
        end
      end
      advance();
    end
    fifo_words = '0;
  endtask

  task automatic test_full_stall();
    int writes;
    writes = 0;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL full_c%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      if (wr_en === 1'b1) writes++;
      if (c >= 3 && c <= 5) begin
        vectors++;
        if ({grant, wr_en} !== 5'b0001_0) begin
          miscompares++;
          $display("[TB] FAIL full_stall_c%0d: got grant=%b wr_en=%b, want grant=0001 wr_en=0", c, grant, wr_en);
        end
      end
      if (c == 7) begin
        vectors++;
        if (grant !== 4'b0000 || writes != 2) begin
          miscompares++;
          $display("[TB] FAIL full_complete: got grant=%b writes=%0d, want grant=0000 writes=2", grant, writes);
        end
      end
      advance();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_drop_and_reset();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      req   = (c == 3) ? 4'b0010 : 4'b0011;
      rst_n = (c != 6);
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL drop_c%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      if (c == 5) begin
        vectors++;
        if (grant !== 4'b0010) begin
          miscompares++;
          $display("[TB] FAIL drop_ptr_advance: got grant=%b, want 0010", grant);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({ack, wr_en} !== 5'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_cycle_write: got ack=%b wr_en=%b, want 0", ack, wr_en);
        end
      end
      if (c == 8) begin
        vectors++;
        if (grant !== 4'b0001) begin
          miscompares++;
          $display("[TB] FAIL post_reset_grant: got grant=%b, want 0001", grant);
        end
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (e_ack[i] || !req[i]) req_data[i*DW +: DW] = DW'($urandom);
        req[i] = ($urandom_range(0, 99) < 70);
      end
      fifo_words = 4'($urandom_range(0, 7));
      fifo_full  = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 99) != 0);
      sample();
      vectors++;
      if ({grant, ack, wr_en, fifo_data, throttled} !== {e_grant, e_ack, e_wr, e_data, e_thr}) begin
        miscompares++;
        $display("[TB] FAIL rand_c%0d: got %s, want %s", c, obs_str(), exp_str());
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    e_ack = '0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_throttle();
    test_full_stall();
    test_drop_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
